// File: rtl/fma_share_arbiter.sv
// fma_share_arbiter
//   Round-robin arbiter and sequencer that time-shares one combinational FP32
//   fused multiply-add datapath (D = A*B + C) between NREQ requesters. One
//   operation is in flight at a time: grant, register operands onto the FMA
//   inputs, wait FMA_CYCLES clocks for the path to settle, capture D into a
//   one-deep response buffer and hold it until the consumer accepts it.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req_valid[NREQ]       per-requester request pending
//   req_ready[NREQ]       one-hot grant, combinational, only while idle
//   req_a/b/c[32*NREQ]    operands, slice [32i+31:32i] belongs to requester i
//   fma_a/b/c[32]         registered operands driven to the FMA datapath
//   fma_d[32]             FMA result
//   rsp_valid/rsp_ready   response handshake
//   rsp_id[IDW]           requester that owns rsp_data
//   rsp_data[32]          captured FMA result, bit-exact
//   busy                  an operation is in flight or awaiting acceptance
module fma_share_arbiter #(
    parameter int NREQ       = 4,
    parameter int FMA_CYCLES = 2,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [32*NREQ-1:0]   req_c,
    output logic [31:0]          fma_a,
    output logic [31:0]          fma_b,
    output logic [31:0]          fma_c,
    input  logic [31:0]          fma_d,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 busy
);

    // The countdown only ever holds FMA_CYCLES-1 down to 0.
    localparam int CNTW = (FMA_CYCLES > 1) ? $clog2(FMA_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT           state;
    stateT           stateNext;
    logic [IDW-1:0]  ptr;
    logic [CNTW-1:0] cnt;
    logic [IDW-1:0]  id;

    logic            grantFound;
    logic [IDW-1:0]  grantIdx;
    logic [IDW-1:0]  ptrNext;
    int              searchIdx;

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        searchIdx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            searchIdx = int'(ptr) + k;
            if (searchIdx >= NREQ) begin
                searchIdx = searchIdx - NREQ;
            end
            if (!grantFound && req_valid[searchIdx]) begin
                grantFound = 1'b1;
                grantIdx   = searchIdx[IDW-1:0];
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        if (int'(grantIdx) == NREQ - 1) begin
            ptrNext = '0;
        end else begin
            ptrNext = grantIdx + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grantFound) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                // rsp_valid is always set in RESP, so rsp_ready alone completes it.
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs: the grant is gated by rst so nothing is accepted during reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && grantFound) begin
            req_ready[grantIdx] = 1'b1;
        end
        busy = (state != IDLE);
    end

    // Grant stage: latch operands and owner, then count down the settle time.
    // Capture stage: sample fma_d once the count expires, hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            id        <= '0;
            fma_a     <= '0;
            fma_b     <= '0;
            fma_c     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        fma_a <= req_a[32*int'(grantIdx) +: 32];
                        fma_b <= req_b[32*int'(grantIdx) +: 32];
                        fma_c <= req_c[32*int'(grantIdx) +: 32];
                        id    <= grantIdx;
                        ptr   <= ptrNext;
                        cnt   <= CNTW'(FMA_CYCLES - 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_data  <= fma_d;
                        rsp_id    <= id;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fma_share_arbiter.md
# fma_share_arbiter

Round-robin arbiter and sequencer that shares the single combinational FP32 fused multiply-add datapath (`Top`, D = A×B + C) between `NREQ` requesters. It grants one requester, registers its operands onto the FMA inputs, and waits a programmable number of cycles for the combinational path to settle. It then captures the result into a one-deep response buffer with a valid/ready handshake. Only one operation is in flight at a time.

## Interface
- `NREQ`, 4 — number of requesters, ≥2
- `FMA_CYCLES`, 2 — clk cycles allotted to the combinational FMA path, ≥1
- `IDW`, $clog2(NREQ) — requester id width (localparam)

- `clk`  in  1  — single clock, rising edge
- `rst`  in  1  — reset, synchronous, active-high
- `req_valid`  in  NREQ  — bit i: requester i has an operation pending
- `req_ready`  out  NREQ  — one-hot grant/accept; combinational, only in IDLE
- `req_a`, `req_b`, `req_c`  in  32*NREQ  — operands; slice [32i+31:32i] belongs to requester i
- `fma_a`, `fma_b`, `fma_c`  out  32  — registered operands to FMA A/B/C
- `fma_d`  in  32  — FMA result D
- `rsp_valid`  out  1  — result available
- `rsp_ready`  in  1  — consumer accepts result
- `rsp_id`  out  IDW  — index of the requester that owns `rsp_data`
- `rsp_data`  out  32  — captured FMA result
- `busy`  out  1  — state ≠ IDLE

## Operation
- States: IDLE, WAIT, RESP. Registers: `ptr` (IDW), `cnt`, `id`, operand regs, response regs.
- IDLE:
  - Search `req_valid` from index `ptr` upward, wrapping modulo NREQ. The first set bit is g.
  - Drive `req_ready[g]`=1; all other bits are 0. If no bit is set, `req_ready`=0 and the block stays in IDLE.
- On grant, at the clock edge:
  - `fma_a/b/c` ← operand slices of g; `id` ← g.
  - `ptr` ← (g+1) mod NREQ.
  - `cnt` ← FMA_CYCLES−1; next state WAIT.
- WAIT:
  - If `cnt`==0: `rsp_data` ← `fma_d`, `rsp_id` ← `id`, `rsp_valid` ← 1, next state RESP.
  - Otherwise `cnt` ← `cnt`−1.
- RESP:
  - `rsp_valid`, `rsp_id` and `rsp_data` are held stable until `rsp_valid & rsp_ready`.
  - On that handshake: `rsp_valid` ← 0, next state IDLE.
  - No grant is issued in the same cycle.
- `req_ready` is 0 in WAIT and RESP regardless of `req_valid`.
- `fma_a/b/c` keep the last operands until the next grant. The FMA inputs never toggle during WAIT.
- Requester contract:
  - Once `req_valid` is high, operands are stable until `req_ready` is seen.
  - Deasserting `req_valid` before a grant is legal and simply removes the request.
- `rsp_ready` while `rsp_valid`=0 is ignored.
- Result bits pass through unmodified (NaN, Inf, denormals included); the block does no arithmetic.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - State IDLE, `ptr`=0, `cnt`=0.
  - `fma_a/b/c`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0.
  - `req_ready`=0 while `rst` is high.
- Reset during WAIT or RESP discards the in-flight operation. No response is produced and nothing is replayed.
- Grant handshake at edge E0 → `fma_*` valid after E0 → `fma_d` sampled at edge E0+FMA_CYCLES → `rsp_valid`=1 from that edge.
- Request-accept to response-valid latency is FMA_CYCLES cycles.
- With `rsp_ready` tied high, back-to-back grant spacing is FMA_CYCLES+2 cycles (IDLE + FMA_CYCLES×WAIT + RESP).
- Backpressure stretches RESP by an arbitrary number of cycles. No request is accepted during that time.
- Fairness: a continuously valid requester is granted within NREQ grants.

## Test plan
- **Single request** (NREQ=4, FMA_CYCLES=2): requester 2 drives A=3F800000, B=40000000, C=40400000; `rsp_ready`=1.
  - `req_ready`=4'b0100 for one cycle.
  - `rsp_valid` rises 2 cycles after the handshake with `rsp_id`=2, `rsp_data`=40A00000.
  - `busy` then drops.
- **All four requesters valid from reset release**: grants in order 0,1,2,3,0, spaced exactly 4 cycles apart; each `rsp_id` matches its grant.
- **Backpressure**: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid`, `rsp_id` and `rsp_data` stay constant; `req_ready`=0.
  - After the handshake, the next grant occurs exactly 1 cycle later.
- **Pointer wrap** (FMA_CYCLES=1): requester 3 alone is served, then requesters 1 and 3 are valid together.
  - Requester 1 is granted first (`ptr`=0); requester 3 follows.
  - Grant spacing is 3 cycles.
- **Reset mid-operation**: assert `rst` for 1 cycle during WAIT.
  - Next cycle all outputs are 0 and the state is IDLE.
  - No response is emitted for the aborted op; the next grant starts from index 0.
- **Special values**: A=7F800000, B=00000000, C=3F800000.
  - `rsp_data` equals `fma_d` bit-exactly (expect 7FC00000 from the reference model).
  - `fma_a/b/c` remain stable through WAIT.
